// File: rtl/hcsr04_meas_sched.sv
// HC-SR04 measurement scheduler: periodic start, echo capture with timeout,
// 4-sample moving average, proximity flag.
module hcsr04_meas_sched #(
  parameter int PERIOD_CYC  = 6000000,
  parameter int TIMEOUT_CYC = 4000000,
  parameter int MAX_MM      = 4000,
  parameter int NEAR_MM     = 300
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        meas_val,
  input  logic [11:0] meas_dist,
  output logic        start,
  output logic [11:0] avg_dist,
  output logic        avg_valid,
  output logic        avg_upd,
  output logic        near,
  output logic        no_echo,
  output logic        range_err
);

  localparam int PW = $clog2(PERIOD_CYC);
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [PW-1:0] P_LAST = PW'(PERIOD_CYC - 1);
  localparam logic [PW-1:0] P_ONE  = PW'(1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] T_ONE  = TW'(1);
  localparam logic [11:0]   MAX_D  = 12'(MAX_MM);
  localparam logic [11:0]   NEAR_D = 12'(NEAR_MM);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    GAP
  } state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    pcnt_q, pcnt_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic [3:0][11:0] w_q, w_d;
  logic [13:0]      sum_q, sum_d;
  logic [2:0]       fill_q, fill_d;
  logic             pend_q, pend_d;
  logic [11:0]      avg_q, avg_d;
  logic             valid_q, valid_d;
  logic             upd_q, upd_d;
  logic             near_q, near_d;
  logic             rerr_q, rerr_d;
  logic             hit;

  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    tcnt_d  = tcnt_q;
    w_d     = w_q;
    sum_d   = sum_q;
    fill_d  = fill_q;
    pend_d  = 1'b0;
    avg_d   = avg_q;
    valid_d = valid_q;
    near_d  = near_q;
    upd_d   = pend_q;
    rerr_d  = 1'b0;
    start   = 1'b0;
    no_echo = 1'b0;
    hit     = 1'b0;

    // running sum already holds the new sample one edge after capture
    if (pend_q) begin
      avg_d   = sum_q[13:2];
      valid_d = (fill_q == 3'd4);
      near_d  = (fill_q == 3'd4) && (sum_q[13:2] < NEAR_D);
    end

    unique case (state_q)
      IDLE: begin
        if (en) state_d = START;
      end
      START: begin
        start   = 1'b1;
        pcnt_d  = P_ONE;
        tcnt_d  = '0;
        state_d = en ? WAIT : IDLE;
      end
      WAIT: begin
        pcnt_d = pcnt_q + P_ONE;
        tcnt_d = tcnt_q + T_ONE;
        if (meas_val) begin
          hit     = 1'b1;
          state_d = GAP;
        end else if (tcnt_q == T_LAST) begin
          no_echo = 1'b1;
          state_d = GAP;
        end
        if (!en) state_d = IDLE;
      end
      GAP: begin
        pcnt_d = pcnt_q + P_ONE;
        if (pcnt_q == P_LAST) state_d = en ? START : IDLE;
        else if (!en)         state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (hit) begin
      if (meas_dist > MAX_D) begin
        rerr_d = 1'b1;
      end else begin
        w_d    = {w_q[2:0], meas_dist};
        sum_d  = sum_q + {2'b00, meas_dist} - {2'b00, w_q[3]};
        fill_d = (fill_q == 3'd4) ? 3'd4 : fill_q + 3'd1;
        pend_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pcnt_q  <= '0;
      tcnt_q  <= '0;
      w_q     <= '0;
      sum_q   <= '0;
      fill_q  <= '0;
      pend_q  <= 1'b0;
      avg_q   <= '0;
      valid_q <= 1'b0;
      upd_q   <= 1'b0;
      near_q  <= 1'b0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      tcnt_q  <= tcnt_d;
      w_q     <= w_d;
      sum_q   <= sum_d;
      fill_q  <= fill_d;
      pend_q  <= pend_d;
      avg_q   <= avg_d;
      valid_q <= valid_d;
      upd_q   <= upd_d;
      near_q  <= near_d;
      rerr_q  <= rerr_d;
    end
  end

  assign avg_dist  = avg_q;
  assign avg_valid = valid_q;
  assign avg_upd   = upd_q;
  assign near      = near_q;
  assign range_err = rerr_q;

endmodule

// File: tb/tb_hcsr04_meas_sched.sv
// Bench for hcsr04_meas_sched: directed and random rounds checked every
// cycle against a cycles-since-start schedule model and a sample queue.
module tb_hcsr04_meas_sched;

  localparam int P  = 2000;
  localparam int T  = 1500;
  localparam int MX = 4000;
  localparam int NR = 300;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        meas_val = 1'b0;
  logic [11:0] meas_dist = '0;
  logic        start, avg_valid, avg_upd, near, no_echo, range_err;
  logic [11:0] avg_dist;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  hcsr04_meas_sched #(
    .PERIOD_CYC (P),
    .TIMEOUT_CYC(T),
    .MAX_MM     (MX),
    .NEAR_MM    (NR)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .meas_val (meas_val),
    .meas_dist(meas_dist),
    .start    (start),
    .avg_dist (avg_dist),
    .avg_valid(avg_valid),
    .avg_upd  (avg_upd),
    .near     (near),
    .no_echo  (no_echo),
    .range_err(range_err)
  );

  function automatic void chk(string nm, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // since: cycles since last start pulse, -1 when no schedule is running
  int  since = -1;
  bit  open_w = 1'b0;
  int  win[$];
  bit  pend = 1'b0;
  int  m_avg = 0;
  bit  m_valid = 1'b0;
  bit  m_near = 1'b0;
  bit  m_upd = 1'b0;
  bit  m_rerr = 1'b0;

  function automatic void model_reset();
    since = -1;
    open_w = 1'b0;
    win.delete();
    pend = 1'b0;
    m_avg = 0;
    m_valid = 1'b0;
    m_near = 1'b0;
    m_upd = 1'b0;
    m_rerr = 1'b0;
  endfunction

  function automatic void advance();
    int s;
    m_upd = pend;
    if (pend) begin
      s = 0;
      foreach (win[i]) s += win[i];
      m_avg   = s / 4;
      m_valid = (win.size() == 4);
      m_near  = m_valid && (m_avg < NR);
    end
    pend = 1'b0;
    m_rerr = 1'b0;
    if (open_w && meas_val) begin
      open_w = 1'b0;
      if (int'(meas_dist) > MX) begin
        m_rerr = 1'b1;
      end else begin
        win.push_front(int'(meas_dist));
        if (win.size() > 4) void'(win.pop_back());
        pend = 1'b1;
      end
    end else if (open_w && since == T) begin
      open_w = 1'b0;
    end
    if (since < 0) begin
      since = en ? 0 : -1;
    end else if (!en) begin
      since = -1;
      open_w = 1'b0;
    end else if (since == P - 1) begin
      since = 0;
    end else begin
      if (since == 0) open_w = 1'b1;
      since++;
    end
  endfunction

  always @(negedge clk) begin
    if (!rst) model_reset();
    chk("start", int'(start), int'(since == 0));
    chk("no_echo", int'(no_echo), int'(open_w && since == T && !meas_val));
    chk("range_err", int'(range_err), int'(m_rerr));
    chk("avg_upd", int'(avg_upd), int'(m_upd));
    chk("avg_dist", int'(avg_dist), m_avg);
    chk("avg_valid", int'(avg_valid), int'(m_valid));
    chk("near", int'(near), int'(m_near));
    if (rst) advance();
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_start(output int t);
    int k;
    k = 0;
    while (!start && k < 3000) begin
      tick();
      k++;
    end
    chk("start_seen", int'(start), 1);
    t = cyc;
  endtask

  task automatic echo(input int d);
    meas_val  = 1'b1;
    meas_dist = 12'(d);
    tick();
    meas_val  = 1'b0;
  endtask

  initial begin
    int t0, t1, k, off, d;
    int e1[4];
    int e2[4];
    e1 = '{250, 500, 750, 1000};
    e2 = '{800, 600, 400, 200};

    #3 rst = 1'b0;
    tick(3);
    chk("rst_avg", int'(avg_dist), 0);
    chk("rst_start", int'(start), 0);
    rst = 1'b1;
    en  = 1'b1;

    wait_start(t0);
    tick();
    wait_start(t1);
    chk("period", t1 - t0, P);
    k = 0;
    tick();
    while (!no_echo && k < 2000) begin
      tick();
      k++;
    end
    chk("tmo_delay", cyc - t1, T);

    foreach (e1[i]) begin
      wait_start(t0);
      tick(100);
      echo(1000);
      tick();
      chk("fill_upd", int'(avg_upd), 1);
      chk("fill_avg", int'(avg_dist), e1[i]);
      chk("fill_valid", int'(avg_valid), int'(i == 3));
    end
    foreach (e2[i]) begin
      wait_start(t0);
      tick(100);
      echo(200);
      tick();
      chk("near_avg", int'(avg_dist), e2[i]);
      chk("near_flag", int'(near), int'(i == 3));
    end

    wait_start(t0);
    tick(100);
    echo(4095);
    chk("rerr_pulse", int'(range_err), 1);
    tick();
    chk("rerr_noupd", int'(avg_upd), 0);
    chk("rerr_avg", int'(avg_dist), 200);
    wait_start(t0);
    tick(100);
    echo(4000);
    tick();
    chk("max_avg", int'(avg_dist), 1150);

    wait_start(t0);
    tick(T);
    meas_val  = 1'b1;
    meas_dist = 12'd500;
    #1;
    chk("tmo_tie_noecho", int'(no_echo), 0);
    tick();
    meas_val = 1'b0;
    tick();
    chk("tmo_tie_upd", int'(avg_upd), 1);
    chk("tmo_tie_avg", int'(avg_dist), 1225);
    tick(100);
    echo(123);
    tick();
    chk("gap_ignored", int'(avg_upd), 0);

    wait_start(t0);
    tick(50);
    en = 1'b0;
    tick(5);
    echo(50);
    tick(3);
    chk("en0_avg", int'(avg_dist), 1225);
    chk("en0_valid", int'(avg_valid), 1);

    en = 1'b1;
    wait_start(t0);
    tick(50);
    rst = 1'b0;
    #1;
    chk("arst_avg", int'(avg_dist), 0);
    chk("arst_valid", int'(avg_valid), 0);
    tick(2);
    rst = 1'b1;
    en  = 1'b0;
    echo(700);
    tick();
    chk("late_val", int'(avg_upd), 0);
    en = 1'b1;
    tick();
    chk("restart", int'(start), 1);

    repeat (12) begin
      wait_start(t0);
      off = $urandom_range(1, T + 100);
      if ($urandom_range(0, 3) == 0) d = $urandom_range(0, 4095);
      else d = $urandom_range(50, 600);
      tick(off);
      if ($urandom_range(0, 9) == 0) en = 1'b0;
      echo(d);
      en = 1'b1;
      tick($urandom_range(1, 300));
      if ($urandom_range(0, 3) == 0) echo($urandom_range(0, 4095));
    end

    tick(5);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/hcsr04_meas_sched.md
Name: hcsr04_meas_sched

Overview:
- Downstream controller for the HC-SR04 ultrasonic ranging block.
- Issues periodic one-cycle start pulses to the ranging block and captures its val/distance result, with a no-echo timeout.
- Keeps a 4-sample moving-average window of valid readings.
- Presents the filtered distance, an update strobe and a proximity flag to the crossbar.

Parameters:
- PERIOD_CYC, 6000000, clk cycles between successive start pulses (60 ms at 100 MHz); must exceed TIMEOUT_CYC+2.
- TIMEOUT_CYC, 4000000, max cycles in WAIT for meas_val after start (40 ms).
- MAX_MM, 4000, largest accepted distance in mm; larger readings are rejected.
- NEAR_MM, 300, proximity threshold in mm.

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  reset, asynchronous, active-low
- en  in  1  enables periodic measurement
- meas_val  in  1  one-cycle result strobe from ranging block
- meas_dist  in  12  ranging result in mm, qualified by meas_val
- start  out  1  one-cycle measurement request to ranging block
- avg_dist  out  12  moving-average distance in mm
- avg_valid  out  1  high once the window holds 4 valid samples
- avg_upd  out  1  one-cycle strobe when avg_dist is updated
- near  out  1  avg_valid && avg_dist < NEAR_MM
- no_echo  out  1  one-cycle pulse on timeout
- range_err  out  1  one-cycle pulse on a rejected reading (meas_dist > MAX_MM)

Behaviour:
- Reset (rst=0): state=IDLE. All of these clear to 0:
  - every output;
  - period counter, timeout counter;
  - window registers w0..w3, 14-bit running sum, fill counter.
- Reset mid-operation aborts any pending measurement. A late meas_val after reset is ignored, because the FSM is in IDLE.

FSM states: IDLE, START, WAIT, GAP.
- IDLE: if en=1, go to START next cycle.
- START:
  - start=1 for exactly this cycle.
  - Period counter loads 1; timeout counter loads 0.
  - Go to WAIT.
- WAIT: period and timeout counters increment each cycle.
  - meas_val=1 → process the sample (below), go to GAP.
  - Else if timeout counter == TIMEOUT_CYC-1 → no_echo=1 for one cycle, go to GAP.
  - Simultaneous meas_val and timeout expiry: the sample wins and no_echo stays 0.
- GAP: period counter increments.
  - At PERIOD_CYC-1, go to START if en=1, else IDLE.
  - Start-to-start spacing is therefore exactly PERIOD_CYC cycles.
- en=0 in START, WAIT or GAP: go to IDLE next cycle.
  - The window, avg outputs and avg_valid are retained.
  - A meas_val arriving in that same cycle is still processed.
- meas_val outside WAIT is ignored; no window change, no pulse.

Sample processing, in the meas_val cycle T:
- meas_dist > MAX_MM: range_err=1 at T+1; window unchanged.
- Otherwise, at the T edge:
  - shift w3<=w2, w2<=w1, w1<=w0, w0<=meas_dist;
  - sum <= sum + meas_dist - w3;
  - fill <= min(fill+1, 4).
- At T+1 edge:
  - avg_dist <= sum[13:2] (truncating divide by 4);
  - avg_valid <= (fill==4);
  - near updates;
  - avg_upd=1 for one cycle.
- Latency: meas_val to avg_upd/avg_dist visible = 2 clk edges.
- Before fill reaches 4, avg_upd still pulses. avg_dist is the sum/4 with empty slots counted as 0; avg_valid=0 and near=0.
- Arithmetic: the sum is 14 bits unsigned. Max 4×4095 = 16380 cannot overflow. The subtraction never underflows, because w3 is always part of the sum.

Test Plan:
(Simulate with PERIOD_CYC=2000, TIMEOUT_CYC=1500, MAX_MM=4000, NEAR_MM=300.)
- Reset then en=1: start pulses 1 cycle wide, consecutive pulses exactly 2000 cycles apart. With no meas_val, no_echo pulses 1500 cycles after each start. avg_upd never fires.
- Return meas_dist 1000, 1000, 1000, 1000 at 100 cycles after each start:
  - avg_upd 2 cycles after each meas_val;
  - avg_dist 250, 500, 750, 1000;
  - avg_valid=1 only after the 4th sample.
- Window full at 1000, then feed 200, 200, 200, 200: avg_dist 800, 600, 400, 200. near=1 only at 200.
- meas_dist=4095 in WAIT: range_err pulse 1 cycle later, avg_dist/window unchanged, no avg_upd. Then feed 4000: accepted.
- meas_val on the exact timeout cycle: the sample is accepted and no_echo=0. meas_val asserted during GAP: ignored.
- en=0 mid-WAIT: start stays 0, outputs retained. Assert rst mid-WAIT: all outputs 0, avg_valid=0; after release with en=1, the first start comes 1 cycle after IDLE.
